// File: rtl/wr_ingress_pkg.sv
// rtl/wr_ingress_pkg.sv - shared framing state encoding and default sizes for wr_ingress
package wr_ingress_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BODY    = 2'd1,
      ST_DISCARD = 2'd2
   } frame_state_t;

   localparam int DEF_D_SIZE  = 8;
   localparam int DEF_MAX_LEN = 16;

endpackage

// File: rtl/wr_skid2.sv
// rtl/wr_skid2.sv - generic two-entry in-order skid buffer
module wr_skid2 #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] data,
   output logic [W-1:0] head,
   output logic [1:0]   cnt
);

   logic [W-1:0] mem [0:1];
   logic         rd_ptr;
   logic         wr_ptr;
   logic         push_ok;
   logic         pop_ok;

   // Guards keep occupancy in 0..2 even if a caller misbehaves.
   assign push_ok = push && (cnt != 2'd2);
   assign pop_ok  = pop && (cnt != 2'd0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         rd_ptr <= rd_ptr ^ pop_ok;
         wr_ptr <= wr_ptr ^ push_ok;
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= data;
      end
   end

endmodule

// File: rtl/wr_ingress.sv
// rtl/wr_ingress.sv - packet framing, truncation and skid buffering ahead of the write FIFO
module wr_ingress
   import wr_ingress_pkg::*;
#(
   parameter int D_SIZE  = DEF_D_SIZE,
   parameter int MAX_LEN = DEF_MAX_LEN
) (
   input  logic              wclk,
   input  logic              wrst,
   input  logic              in_valid,
   input  logic [D_SIZE-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   input  logic              full,
   output logic              wen,
   output logic [D_SIZE:0]   wdata,
   output logic              trunc_err,
   output logic [15:0]       pkt_cnt
);

   localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

   frame_state_t      state, state_nx;
   logic [7:0]        len, len_nx;
   logic              accept;
   logic              push;
   logic              set_trunc;
   logic [D_SIZE:0]   push_word;
   logic [D_SIZE:0]   head;
   logic [1:0]        cnt;

   wr_skid2 #(.W(D_SIZE + 1)) u_skid (
      .clk  (wclk),
      .rst  (wrst),
      .push (push),
      .pop  (wen),
      .data (push_word),
      .head (head),
      .cnt  (cnt)
   );

   assign in_ready = (cnt != 2'd2);
   assign accept   = in_valid && in_ready;
   assign wen      = (cnt != 2'd0) && !full;
   assign wdata    = head;

   always_ff @(posedge wclk) begin
      if (wrst) begin
         state     <= ST_IDLE;
         len       <= 8'd0;
         trunc_err <= 1'b0;
         pkt_cnt   <= 16'd0;
      end else begin
         state <= state_nx;
         len   <= len_nx;
         if (set_trunc) begin
            trunc_err <= 1'b1;
         end
         if (wen && head[D_SIZE] && (pkt_cnt != 16'hFFFF)) begin
            pkt_cnt <= pkt_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      len_nx    = len;
      push      = 1'b0;
      set_trunc = 1'b0;
      push_word = {in_last, in_data};
      if (accept) begin
         case (state)
            ST_IDLE: begin
               push = 1'b1;
               if (!in_last) begin
                  len_nx   = 8'd1;
                  state_nx = ST_BODY;
               end
            end
            ST_BODY: begin
               push = 1'b1;
               if (in_last) begin
                  len_nx   = 8'd0;
                  state_nx = ST_IDLE;
               end else if (({1'b0, len} + 9'd1) < MAX_LEN_W) begin
                  len_nx = len + 8'd1;
               end else begin
                  // Packet hit its length cap: close it here and drop the rest.
                  push_word = {1'b1, in_data};
                  set_trunc = 1'b1;
                  len_nx    = 8'd0;
                  state_nx  = ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (in_last) begin
                  state_nx = ST_IDLE;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

endmodule
